command_issuer: RTL
===================

COMMAND_ISSUER -- requirements
Module: command_issuer

Interface
REQ-001 Parameter DEPTH, default 8: command FIFO depth; power of two, at least 2.
REQ-002 Parameter ALU_GAP, default 5: cycles between consecutive syscall pulses for non-CAS commands; at least 3.
REQ-003 Parameter CAS_GAP, default 5: cycles between a CAS syscall pulse and the next syscall pulse; at least 3.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  an upstream command is offered this cycle.
REQ-007 in_ready  out  1  the FIFO accepts a command this cycle.
REQ-008 in_cmd  in  12  command: [11:9] opcode, [8:6] addr1, [5:3] addr2, [2:0] addr3.
REQ-009 command  out  12  command presented to the register/ALU controller.
REQ-010 syscall  out  1  one-cycle RUN pulse to the controller.
REQ-011 busy  out  1  FIFO is non-empty or the FSM is not in IDLE.
REQ-012 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 issued_cnt  out  16  number of syscall pulses issued.
REQ-014 reject  out  1  one-cycle pulse when a popped command is dropped.

Function
REQ-015 A command is pushed at a rising edge when in_valid and in_ready are both 1.
REQ-016 in_ready SHALL equal the registered not-full flag; a pop in the same cycle does not allow a push into a full FIFO.
REQ-017 The FSM has three states: IDLE, ISSUE, WAIT.
REQ-018 IDLE, FIFO non-empty: the head is popped into the command register and the FSM moves to ISSUE. IDLE, FIFO empty: the FSM stays in IDLE.
REQ-019 ISSUE: syscall is 1 for exactly this cycle. wait_cnt is loaded with GAP-2, where GAP is CAS_GAP for opcode 3'b111 and ALU_GAP otherwise. The FSM moves to WAIT.
REQ-020 WAIT: wait_cnt decrements each cycle. When wait_cnt reaches 1, the FSM moves to IDLE.
REQ-021 Consequence of REQ-018 to REQ-020: with the FIFO continuously non-empty, syscall rising edges are exactly GAP cycles apart.
REQ-022 The command output holds its value from ISSUE until the next pop; it never changes while syscall is 1.
REQ-023 Latency: a push at edge E into an empty FIFO with the FSM in IDLE produces syscall high in the cycle after edge E+2.
REQ-024 issued_cnt increments in each ISSUE cycle and wraps from 0xFFFF to 0x0000.
REQ-025 level updates as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-026 FIFO read and write pointers wrap modulo DEPTH.

Reset
REQ-027 While rst_n is 0, and immediately on its assertion, the following hold:
- FSM is in IDLE and FIFO is empty.
- command = 0, syscall = 0, reject = 0, level = 0, issued_cnt = 0.
- in_ready = 1, busy = 0.
REQ-028 A reset asserted during ISSUE or WAIT aborts the pending wait. Queued commands are discarded. No syscall follows the deassertion of reset until a new push occurs.

Configuration
REQ-029 Macro ISSUER_CAS_EN, defined: opcode 3'b111 commands are issued normally using CAS_GAP.
REQ-030 Macro ISSUER_CAS_EN, undefined: an opcode 3'b111 command popped in IDLE is dropped. reject pulses for one cycle, command is unchanged, no syscall is issued, the FSM stays in IDLE, and issued_cnt is unchanged. CAS_GAP is unused.

Structure
REQ-031 Shared package alu_pkg SHALL hold:
- the opcode typedef (3 bits) and the constant OP_CAS = 3'b111;
- the command field bit positions;
- the issuer state enum.
REQ-032 The FIFO SHALL be a sub-module cmd_fifo, parameterized by DEPTH and WIDTH = 12, with push/pop ports, full/empty flags and a level output.

Verification
REQ-033 Reset, then push 12'h0D1 into an idle issuer at edge 0 -> syscall high in cycle 3; command = 12'h0D1; issued_cnt = 1.
REQ-034 Push 3 non-CAS commands back-to-back with ALU_GAP = 5 -> syscall rises in cycles 3, 8 and 13; commands appear in push order; busy falls after the last WAIT.
REQ-035 Push 9 commands with in_valid held at 1 and DEPTH = 8 -> in_ready falls at level 8; the 9th command is accepted only after the first pop; no command is lost or duplicated.
REQ-036 Push 12'hE53 (CAS opcode):
- ISSUER_CAS_EN defined, CAS_GAP = 6 -> syscall issued; the next syscall comes 6 cycles later.
- ISSUER_CAS_EN undefined -> reject pulses once; no syscall is issued.
REQ-037 Assert rst_n = 0 during WAIT with 4 commands queued -> syscall = 0, level = 0, issued_cnt = 0 immediately; no syscall after release.
REQ-038 Preload issued_cnt to 0xFFFF through a sequence of 65535 issues, then issue once more -> issued_cnt = 0x0000.

Source files
------------

// File: rtl/command_issuer_pkg.sv
// Shared definitions for the command issuer: opcode type, command field
// positions and the issuer FSM state encoding.
package alu_pkg;

  localparam int CMD_W = 12;

  // Command field bit positions: [11:9] opcode, [8:6] addr1, [5:3] addr2, [2:0] addr3
  localparam int OP_HI = 11;
  localparam int OP_LO = 9;
  localparam int A1_HI = 8;
  localparam int A1_LO = 6;
  localparam int A2_HI = 5;
  localparam int A2_LO = 3;
  localparam int A3_HI = 2;
  localparam int A3_LO = 0;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_CAS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } issuer_state_t;

  function automatic opcode_t cmd_opcode(input logic [CMD_W-1:0] cmd);
    return cmd[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] cmd_addr1(input logic [CMD_W-1:0] cmd);
    return cmd[A1_HI:A1_LO];
  endfunction

  function automatic logic [2:0] cmd_addr2(input logic [CMD_W-1:0] cmd);
    return cmd[A2_HI:A2_LO];
  endfunction

  function automatic logic [2:0] cmd_addr3(input logic [CMD_W-1:0] cmd);
    return cmd[A3_HI:A3_LO];
  endfunction

endpackage

// File: rtl/command_issuer_if.sv
// Bus between the command source and the issuer.
// Handshake: a command transfers on a rising clk edge when in_valid and
// in_ready are both 1; in_ready does not depend on in_valid, and the source
// holds in_cmd stable while in_valid is 1 and in_ready is 0.
interface command_issuer_if #(
  parameter int DEPTH = 8
);
  import alu_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [CMD_W-1:0]       in_cmd;
  logic [CMD_W-1:0]       command;
  logic                   syscall;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]            issued_cnt;
  logic                   reject;

  modport master (
    output in_valid, in_cmd,
    input  in_ready, command, syscall, busy, level, issued_cnt, reject
  );

  modport slave (
    input  in_valid, in_cmd,
    output in_ready, command, syscall, busy, level, issued_cnt, reject
  );

endinterface

// File: rtl/command_issuer_cmd_fifo.sv
// Command FIFO for the issuer. A freshly written entry becomes visible to the
// reader one cycle after the write, so empty lags a push into an empty FIFO
// by one cycle; level always reports the true occupancy.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             push_d_q;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses pushes even if a pop happens in the same cycle
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty;
  // The entry written last cycle is not yet readable
  assign empty   = (level_q == {{(LW-1){1'b0}}, push_d_q});

  // Occupancy update: push only +1, pop only -1, both unchanged
  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      push_d_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_d;
      full_q   <= (level_d == LW'(DEPTH));
      push_d_q <= push_ok;
    end
  end

  // Storage array, no reset needed: contents are qualified by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = full_q;
  assign level    = level_q;

endmodule

// File: rtl/command_issuer.sv
// Command issuer: queues commands and hands them one at a time to the
// register/ALU controller with a one-cycle syscall pulse, spacing pulses by
// ALU_GAP (or CAS_GAP after a CAS command).
// Optional feature macro: ISSUER_CAS_EN. When undefined, CAS commands are
// dropped with a one-cycle reject pulse instead of being issued.
module command_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ALU_GAP = 5,
  parameter int CAS_GAP = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  command_issuer_if.slave bus,
  output issuer_state_t   state_dbg
);

`ifdef ISSUER_CAS_EN
  localparam bit CAS_EN = 1'b1;
`else
  localparam bit CAS_EN = 1'b0;
`endif

  localparam int GAP_MAX = (CAS_EN && (CAS_GAP > ALU_GAP)) ? CAS_GAP : ALU_GAP;
  localparam int WAIT_W  = $clog2(GAP_MAX + 1);

  issuer_state_t          state_q;
  issuer_state_t          state_d;
  logic [WAIT_W-1:0]      wait_q;
  logic [WAIT_W-1:0]      wait_d;
  logic [CMD_W-1:0]       command_q;
  logic [15:0]            issued_q;
  logic                   reject_q;
  logic                   fifo_pop;
  logic                   load_cmd;
  logic                   drop;
  logic [CMD_W-1:0]       fifo_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   head_is_cas;
  logic                   cmd_is_cas;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.in_valid),
    .push_data (bus.in_cmd),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_is_cas = (cmd_opcode(fifo_data) == OP_CAS);
  assign cmd_is_cas  = CAS_EN && (cmd_opcode(command_q) == OP_CAS);

  // Next-state logic: pop in IDLE, pulse in ISSUE, count down the gap in WAIT
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    fifo_pop = 1'b0;
    load_cmd = 1'b0;
    drop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_is_cas && !CAS_EN) begin
            drop = 1'b1;
          end else begin
            load_cmd = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // IDLE + ISSUE account for two cycles of the gap
        state_d = ST_WAIT;
        wait_d  = cmd_is_cas ? WAIT_W'(CAS_GAP - 2) : WAIT_W'(ALU_GAP - 2);
      end
      ST_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, gap counter, command register, issue counter and reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      command_q <= '0;
      issued_q  <= '0;
      reject_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      reject_q <= drop;
      if (load_cmd) command_q <= fifo_data;
      if (state_q == ST_ISSUE) issued_q <= issued_q + 16'd1;
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.command    = command_q;
  assign bus.syscall    = (state_q == ST_ISSUE);
  assign bus.busy       = (fifo_level != '0) || (state_q != ST_IDLE);
  assign bus.level      = fifo_level;
  assign bus.issued_cnt = issued_q;
  assign bus.reject     = reject_q;
  assign state_dbg      = state_q;

endmodule
